// File: rtl/data_bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the bridge.
interface data_bus_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        m0_en,    m1_en;
  logic [DATA_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              m0_ready, m1_ready;
  logic [1:0]        bus_en;
  logic [DATA_W-1:0] bus_addr, bus_wdata, bus_rdata;
  logic              bus_ack;
  logic              grant_id;
  logic              timeout_err;

  modport slave (
    input  m0_en, m0_addr, m0_wdata, m1_en, m1_addr, m1_wdata, bus_rdata, bus_ack,
    output m0_rdata, m0_ready, m1_rdata, m1_ready, bus_en, bus_addr, bus_wdata,
           grant_id, timeout_err
  );

  modport master (
    output m0_en, m0_addr, m0_wdata, m1_en, m1_addr, m1_wdata, bus_rdata, bus_ack,
    input  m0_rdata, m0_ready, m1_rdata, m1_ready, bus_en, bus_addr, bus_wdata,
           grant_id, timeout_err
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter onto a single ack-handshaked data bus,
// with a timeout that completes the transaction if the target stays silent.
module data_bus_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [1:0]        en,
  input  logic              load,
  input  logic              done,
  input  logic [DATA_W-1:0] cap_data,
  output logic              vld,
  output logic              ready,
  output logic [DATA_W-1:0] rdata
);
  // 11 is deliberately not a request
  assign vld   = (en == 2'b01) || (en == 2'b10);
  assign ready = done;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst)  rdata <= '0;
    else if (load) rdata <= cap_data;
  end
endmodule

module data_bus_arbiter #(
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  data_bus_arbiter_if.slave  bus_if
);
  localparam int NUM_M = 2;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                        state, nxt;
  logic [NUM_M-1:0][1:0]         m_en;
  logic [NUM_M-1:0][DATA_W-1:0]  m_addr, m_wdata, m_rdata;
  logic [NUM_M-1:0]              m_vld, m_ready, m_load, m_done;

  logic [1:0]        lat_en;
  logic [DATA_W-1:0] lat_addr, lat_wdata, cap_data;
  logic              gid, rr, to_q;
  logic [CW-1:0]     cnt;
  logic              take, grant, fin, fin_to;

  assign m_en    = {bus_if.m1_en,    bus_if.m0_en};
  assign m_addr  = {bus_if.m1_addr,  bus_if.m0_addr};
  assign m_wdata = {bus_if.m1_wdata, bus_if.m0_wdata};

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign m_load[i] = fin && (gid == i[0]);
    assign m_done[i] = (state == DONE) && (gid == i[0]);
    data_bus_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .cpu_clk  (cpu_clk),
      .cpu_rst  (cpu_rst),
      .en       (m_en[i]),
      .load     (m_load[i]),
      .done     (m_done[i]),
      .cap_data (cap_data),
      .vld      (m_vld[i]),
      .ready    (m_ready[i]),
      .rdata    (m_rdata[i])
    );
  end

  always_comb begin
    nxt    = state;
    take   = 1'b0;
    grant  = 1'b0;
    fin    = 1'b0;
    fin_to = 1'b0;
    unique case (state)
      IDLE: if (|m_vld) begin
        take  = 1'b1;
        grant = (&m_vld) ? rr : m_vld[1];
        nxt   = ISSUE;
      end
      ISSUE: begin
        // ack wins over timeout when both land on the last wait cycle
        if (bus_if.bus_ack) begin
          fin = 1'b1;
          nxt = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          fin    = 1'b1;
          fin_to = 1'b1;
          nxt    = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign cap_data = fin_to ? ERR_DATA :
                    (lat_en == 2'b01) ? bus_if.bus_rdata : '0;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state     <= IDLE;
      lat_en    <= 2'b00;
      lat_addr  <= '1;
      lat_wdata <= '0;
      gid       <= 1'b0;
      rr        <= 1'b0;
      cnt       <= '0;
      to_q      <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        lat_en    <= m_en[grant];
        lat_addr  <= m_addr[grant];
        lat_wdata <= m_wdata[grant];
        gid       <= grant;
        cnt       <= '0;
      end
      if (state == ISSUE && !fin) cnt <= cnt + 1'b1;
      if (fin)                    to_q <= fin_to;
      if (state == DONE)          rr   <= ~gid;
    end
  end

  // Bus side is pure decode of state, so an async reset clears it immediately
  assign bus_if.bus_en      = (state == ISSUE) ? lat_en : 2'b00;
  assign bus_if.bus_addr    = (state == ISSUE) ? lat_addr : '1;
  assign bus_if.bus_wdata   = (state == ISSUE && lat_en == 2'b10) ? lat_wdata : '0;
  assign bus_if.grant_id    = gid;
  assign bus_if.timeout_err = (state == DONE) && to_q;
  assign bus_if.m0_ready    = m_ready[0];
  assign bus_if.m1_ready    = m_ready[1];
  assign bus_if.m0_rdata    = m_rdata[0];
  assign bus_if.m1_rdata    = m_rdata[1];
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Transaction-level bench: predicts grant, latency and returned data per request.
module tb_data_bus_arbiter;
  localparam int DW = 32;
  localparam int TO = 15;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  data_bus_arbiter_if #(.DATA_W(DW)) bif ();

  data_bus_arbiter #(.DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus_if  (bif.slave)
  );

  int          tests = 0;
  int          fails = 0;
  logic        model_rr;
  logic [31:0] model_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic [1:0] e, input logic [31:0] a, input logic [31:0] w);
    if (i == 0) begin bif.m0_en = e; bif.m0_addr = a; bif.m0_wdata = w; end
    else        begin bif.m1_en = e; bif.m1_addr = a; bif.m1_wdata = w; end
  endtask

  function automatic logic is_req(input logic [1:0] e);
    return (e == 2'b01) || (e == 2'b10);
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, ".bus_en"},   {30'd0, bif.bus_en}, 32'd0);
    chk({tag, ".bus_addr"}, bif.bus_addr, 32'hFFFF_FFFF);
    chk({tag, ".bus_wdata"}, bif.bus_wdata, 32'd0);
    chk({tag, ".ready"},    {30'd0, bif.m1_ready, bif.m0_ready}, 32'd0);
    chk({tag, ".tmo"},      {31'd0, bif.timeout_err}, 32'd0);
    chk({tag, ".rd0"},      bif.m0_rdata, model_rd[0]);
    chk({tag, ".rd1"},      bif.m1_rdata, model_rd[1]);
  endtask

  // Entered and left at a falling edge inside an IDLE cycle.
  // ack_at = index of the ISSUE cycle in which the target acks; >= TO means never.
  task automatic txn(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                     input logic [31:0] a0, input logic [31:0] w0,
                     input logic [31:0] a1, input logic [31:0] w1,
                     input int ack_at, input logic [31:0] rd);
    logic        g, timed;
    logic [1:0]  ge;
    logic [31:0] ga, gw, exp_rd;
    int          n_issue;
    set_m(0, e0, a0, w0);
    set_m(1, e1, a1, w1);
    bif.bus_ack   = 1'($urandom);
    bif.bus_rdata = $urandom;
    if (!is_req(e0) && !is_req(e1)) begin
      repeat (3) begin
        @(posedge cpu_clk); @(negedge cpu_clk);
        idle_chk({tag, ".none"});
        bif.bus_ack = 1'($urandom);
      end
      bif.bus_ack = 1'b0;
      return;
    end
    g       = (is_req(e0) && is_req(e1)) ? model_rr : is_req(e1);
    ge      = g ? e1 : e0;
    ga      = g ? a1 : a0;
    gw      = g ? w1 : w0;
    timed   = (ack_at >= TO);
    n_issue = timed ? TO : ack_at + 1;
    exp_rd  = timed ? 32'hDEAD_BEEF : (ge == 2'b01) ? rd : 32'd0;
    for (int k = 0; k < n_issue; k++) begin
      @(posedge cpu_clk); @(negedge cpu_clk);
      chk({tag, ".iss.bus_en"},   {30'd0, bif.bus_en}, {30'd0, ge});
      chk({tag, ".iss.bus_addr"}, bif.bus_addr, ga);
      chk({tag, ".iss.bus_wdata"}, bif.bus_wdata, (ge == 2'b10) ? gw : 32'd0);
      chk({tag, ".iss.grant"},    {31'd0, bif.grant_id}, {31'd0, g});
      chk({tag, ".iss.ready"},    {30'd0, bif.m1_ready, bif.m0_ready}, 32'd0);
      bif.bus_ack   = (k == ack_at);
      bif.bus_rdata = (k == ack_at) ? rd : $urandom;
      // the waiting master may wander; the bus must not follow it
      if (g) set_m(0, e0, $urandom, $urandom);
      else   set_m(1, e1, $urandom, $urandom);
    end
    model_rd[g] = exp_rd;
    @(posedge cpu_clk); @(negedge cpu_clk);
    chk({tag, ".done.bus_en"},   {30'd0, bif.bus_en}, 32'd0);
    chk({tag, ".done.bus_addr"}, bif.bus_addr, 32'hFFFF_FFFF);
    chk({tag, ".done.ready"},    {30'd0, bif.m1_ready, bif.m0_ready}, g ? 32'd2 : 32'd1);
    chk({tag, ".done.rd0"},      bif.m0_rdata, model_rd[0]);
    chk({tag, ".done.rd1"},      bif.m1_rdata, model_rd[1]);
    chk({tag, ".done.tmo"},      {31'd0, bif.timeout_err}, {31'd0, timed});
    chk({tag, ".done.grant"},    {31'd0, bif.grant_id}, {31'd0, g});
    bif.bus_ack = 1'($urandom);
    model_rr    = ~g;
    @(posedge cpu_clk); @(negedge cpu_clk);
    idle_chk({tag, ".idle"});
    chk({tag, ".idle.grant"}, {31'd0, bif.grant_id}, {31'd0, g});
    bif.bus_ack = 1'b0;
  endtask

  initial begin
    set_m(0, 2'b00, 32'd0, 32'd0);
    set_m(1, 2'b00, 32'd0, 32'd0);
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'd0;
    model_rr      = 1'b0;
    model_rd[0]   = 32'd0;
    model_rd[1]   = 32'd0;

    #2;
    idle_chk("rst");
    chk("rst.grant", {31'd0, bif.grant_id}, 32'd0);
    @(negedge cpu_clk); @(negedge cpu_clk);
    cpu_rst = 1'b1;

    txn("rd_m0",  2'b01, 2'b00, 32'h8010, 32'h0, 32'h0, 32'h0, 0, 32'h1234_5678);
    txn("wr_m1",  2'b00, 2'b10, 32'h0, 32'h0, 32'h4, 32'hA5A5_A5A5, 2, 32'h5555_AAAA);
    for (int i = 0; i < 6; i++)
      txn("cont", 2'b01, 2'b01, 32'h100, 32'h0, 32'h200, 32'h0, i % 3, $urandom);
    txn("tmo",    2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, TO + 5, 32'h0);
    txn("post",   2'b01, 2'b00, 32'h44, 32'h0, 32'h0, 32'h0, 1, 32'hCAFE_F00D);
    txn("lastw",  2'b00, 2'b01, 32'h0, 32'h0, 32'h48, 32'h0, TO - 1, 32'h0BAD_F00D);
    txn("ill",    2'b11, 2'b00, 32'h50, 32'h1, 32'h0, 32'h0, 0, 32'h0);
    txn("ill_m1", 2'b11, 2'b01, 32'h50, 32'h1, 32'h60, 32'h0, 0, 32'h7777_0000);
    txn("pre_rst", 2'b10, 2'b00, 32'h70, 32'h9, 32'h0, 32'h0, 0, 32'h0);

    // reset in the middle of a transaction; rr was left pointing at m1
    set_m(0, 2'b01, 32'h80, 32'h0);
    set_m(1, 2'b01, 32'h90, 32'h0);
    @(posedge cpu_clk); @(negedge cpu_clk);
    chk("mid.iss.grant", {31'd0, bif.grant_id}, 32'd1);
    #1 cpu_rst = 1'b0;
    #1;
    model_rr    = 1'b0;
    model_rd[0] = 32'd0;
    model_rd[1] = 32'd0;
    idle_chk("mid.rst");
    chk("mid.rst.grant", {31'd0, bif.grant_id}, 32'd0);
    @(negedge cpu_clk);
    idle_chk("mid.hold");
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    txn("after_rst", 2'b01, 2'b01, 32'h80, 32'h0, 32'h90, 32'h0, 0, 32'h1111_2222);

    for (int i = 0; i < 40; i++)
      txn("rand", 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
          $urandom_range(0, TO + 1), $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data bus (DRAM/peripheral bridge side) between two masters: m0 is the CPU data port, m1 is the debug/DMA loader port.
- Each granted request becomes one bus transaction with a ready/ack handshake.
- Round-robin fairness and a timeout guard against a silent target.
- Sits between the CPU's en/addr/wdata/rdata interface and the bridge.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT, 15, max cycles waiting for bus_ack before forced completion (must be ≥1).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- cpu_clk  input  1  clock, all logic on rising edge.
- cpu_rst  input  1  reset, asynchronous, active-low.
- m0_en  input  2  m0 request: 00 none, 01 read, 10 write, 11 treated as none.
- m0_addr  input  DATA_W  m0 byte address.
- m0_wdata  input  DATA_W  m0 write data.
- m0_rdata  output  DATA_W  m0 read data, valid while m0_ready=1.
- m0_ready  output  1  one-cycle completion pulse to m0.
- m1_en, m1_addr, m1_wdata, m1_rdata, m1_ready  as m0, for m1.
- bus_en  output  2  transaction type driven to bridge (01 read, 10 write, 00 idle).
- bus_addr  output  DATA_W  bridge address; 32'hFFFF_FFFF when bus_en=00.
- bus_wdata  output  DATA_W  bridge write data; 0 when bus_en≠10.
- bus_rdata  input  DATA_W  bridge read data, sampled on the cycle bus_ack=1.
- bus_ack  input  1  bridge completion; may be high in the first ISSUE cycle.
- grant_id  output  1  owner of current/last transaction (0=m0, 1=m1).
- timeout_err  output  1  one-cycle pulse when a transaction completes by timeout.

Behaviour:
- Reset values: state IDLE, bus_en=00, bus_addr=32'hFFFF_FFFF, bus_wdata=0, m0/m1_ready=0, m0/m1_rdata=0, grant_id=0, timeout_err=0, rr pointer=0 (m0 preferred), timeout counter=0.
- Reset assertion mid-transaction aborts immediately: outputs return to reset values, no ready pulse is issued, and the masters must re-request.
- FSM states IDLE, ISSUE, DONE.
- IDLE: on each edge, sample valid requests (en = 01 or 10).
  - None valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the master indicated by the rr pointer.
  - On grant: latch en/addr/wdata into internal registers, set grant_id, clear the counter, go to ISSUE.
- ISSUE: bus_en/bus_addr/bus_wdata are driven from the latched registers (stable for the whole transaction regardless of master inputs).
  - bus_ack=1: capture bus_rdata (reads only; writes capture 0), go to DONE.
  - Else, counter==TIMEOUT-1: capture ERR_DATA, pulse timeout_err in DONE, go to DONE.
  - Else: counter+1, stay in ISSUE.
- DONE: bus_en=00.
  - The granted master's ready=1 and its rdata = captured value for exactly this cycle; the other master's ready=0.
  - rr pointer set to the non-granted master.
  - Next state IDLE.
- rdata of each master holds its last value between completions.
- Latency:
  - Request sampled at edge N, ISSUE during cycle N+1, ack during N+1 → ready during N+2. Minimum 2 cycles.
  - Each extra ack wait cycle adds 1. Timeout case: ready TIMEOUT+1 cycles after the grant edge.
- Master rule: hold en/addr/wdata until ready is seen, then drop or change.
  - A request still valid in IDLE after ready is treated as a new transaction (back-to-back allowed, 1 idle cycle between bus transactions).
- A request that changes while not granted is simply resampled; the arbiter keeps no queue.
- bus_ack outside ISSUE is ignored.
- en=11 is never granted and never reaches the bus.

Test Plan:
- Single read: m0_en=01, addr=0x8010, bus_ack in first ISSUE cycle with bus_rdata=0x1234_5678 → bus_en=01 for 1 cycle, m0_ready=1 and m0_rdata=0x1234_5678 two cycles after request, grant_id=0.
- Write with waits: m1_en=10, addr=0x4, wdata=0xA5A5_A5A5, ack after 3 ISSUE cycles → bus_wdata=0xA5A5_A5A5 held 3 cycles, m1_ready pulse in cycle 5, m1_rdata=0.
- Contention: both masters request reads continuously from reset → grants alternate m0,m1,m0,m1; no master is granted twice in a row while the other waits.
- Timeout: m0 read, bus_ack never asserted → after 15 ISSUE cycles, m0_ready=1, m0_rdata=0xDEAD_BEEF, timeout_err=1 for one cycle; next request proceeds normally.
- Reset mid-op: drive cpu_rst=0 during ISSUE → bus_en=00 and bus_addr=0xFFFF_FFFF without waiting for a clock edge; no ready pulse; after release, rr prefers m0.
- Illegal/idle: m0_en=11, m1_en=00 → bus_en stays 00, bus_addr stays 0xFFFF_FFFF, no ready pulses.
